// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch queue between imem port and IF/ID register
//
// Purpose:
//   Issues in-order word fetches ahead of the pipeline. Fetched {pc,inst} pairs are buffered
//   in a DEPTH-entry FIFO. The head entry is presented to the ID stage with a valid/ready
//   handshake. A redirect flushes the FIFO. Responses still in flight for the old stream
//   are discarded as they return.
//
// Configuration macro:
//   IFQ_BYPASS_EN - when the queue is empty, a kept response drives inst_* in the same cycle.
//
// Ports:
//   clk, rst                          core clock, asynchronous active-high reset
//   redirect, redirect_pc             flush and restart fetch at redirect_pc (word aligned)
//   imem_req_valid/ready/addr         fetch request channel
//   imem_resp_valid/data              in-order fetch responses
//   inst_valid/ready, inst_out, pc_out head entry toward the ID stage
//   occupancy                         number of queued entries

module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [31:0]                imem_req_addr,
    input  logic                       imem_resp_valid,
    input  logic [31:0]                imem_resp_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_out,
    output logic [31:0]                pc_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [CW-1:0] count;
    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic [CW:0]   outstanding;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          resp_ok;
    logic          resp_keep;
    logic          resp_drop;
    logic          pop_fifo;
    logic          push_fifo;
    logic          byp_take;

    // Every queued entry and every outstanding request holds a slot, so the queue
    // can never overflow no matter how responses and pops interleave.
    assign outstanding = {1'b0, live} + {1'b0, drop};
    assign credit_used = {1'b0, count} + outstanding;

    // Gated by rst so the request channel stays quiet while reset is held.
    assign imem_req_valid = !rst && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a memory-side protocol error; ignore it.
    assign resp_ok   = imem_resp_valid && (outstanding != '0);
    assign resp_drop = resp_ok && (drop != '0);
    assign resp_keep = resp_ok && (drop == '0);

    assign pop_fifo  = (count != '0) && inst_ready && !redirect;
    assign push_fifo = resp_keep && !redirect && !byp_take;
    assign occupancy = count;

`ifdef IFQ_BYPASS_EN
    logic byp_active;

    assign byp_active = resp_keep && !redirect && (count == '0);
    assign byp_take   = byp_active && inst_ready;
    assign inst_valid = (count != '0) || byp_active;
    assign inst_out   = byp_active ? imem_resp_data : mem_inst[rd_ptr];
    assign pc_out     = byp_active ? resp_pc : mem_pc[rd_ptr];
`else
    assign byp_take   = 1'b0;
    assign inst_valid = (count != '0);
    assign inst_out   = mem_inst[rd_ptr];
    assign pc_out     = mem_pc[rd_ptr];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            live     <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (redirect) begin
            // Everything outstanding, plus a request firing now, belongs to the old
            // stream; a response arriving now retires one of those.
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            resp_pc  <= {redirect_pc[31:2], 2'b00};
            live     <= '0;
            drop     <= drop + live + CW'(req_fire) - CW'(resp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            live <= live + CW'(req_fire) - CW'(resp_keep);
            drop <= drop - CW'(resp_drop);
            if (resp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (push_fifo) begin
                mem_pc[wr_ptr]   <= resp_pc;
                mem_inst[wr_ptr] <= imem_resp_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_fifo) - CW'(pop_fifo);
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - self-checking bench for if_prefetch_queue

module tb_if_prefetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [2:0]  occupancy;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .pc_out(pc_out), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int tag; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    req_t        pend[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_out = 0;
    logic [31:0] m_fetch = RESET_PC;
    logic        m_v = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_tag = 0;
    logic [31:0] cur_addr = '0;
    int          cur_tag = 0;
    bit          kept, byp, pop, fire, ev;
    ent_t        exp_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory response driver: presents what the model scheduled at the previous negedge.
    always @(posedge clk) begin
        #1;
        imem_resp_valid = m_v;
        imem_resp_data  = mem_word(m_addr);
        cur_addr        = m_addr;
        cur_tag         = m_tag;
    end

    // Reference model and per-cycle compare. Requests carry the stream epoch they were
    // issued in; a redirect starts a new epoch, so stale responses are simply those
    // whose epoch no longer matches.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_inst_valid", inst_valid, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_pc_out", pc_out, 0);
            chk("rst_inst_out", inst_out, 0);
            q.delete();
            pend.delete();
            epoch   = 0;
            m_fetch = RESET_PC;
        end else begin
            last_out = pend.size() + (imem_resp_valid ? 1 : 0);
            kept = imem_resp_valid && (cur_tag == epoch) && !redirect;
            byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
            byp  = kept && (q.size() == 0);
`endif
            ev = (q.size() != 0) || byp;
            if (q.size() != 0) exp_e = q[0];
            else exp_e = '{cur_addr, mem_word(cur_addr)};
            chk("inst_valid", inst_valid, ev);
            if (ev) begin
                chk("pc_out", pc_out, exp_e.pc);
                chk("inst_out", inst_out, exp_e.inst);
            end
            chk("occupancy", occupancy, q.size());
            chk("req_valid", imem_req_valid, (q.size() + last_out) < DEPTH);
            if (imem_req_valid) chk("req_addr", imem_req_addr, m_fetch);

            fire = imem_req_valid && imem_req_ready;
            pop  = !redirect && inst_ready && ev;
            if (fire) pend.push_back('{imem_req_addr, epoch, cyc + lat});
            if (redirect) begin
                q.delete();
                epoch++;
                m_fetch = {redirect_pc[31:2], 2'b00};
            end else begin
                if (fire) m_fetch += 32'd4;
                if (pop && q.size() != 0) void'(q.pop_front());
                if (kept && !(byp && pop)) q.push_back('{cur_addr, mem_word(cur_addr)});
            end
        end
        cyc++;
        m_v = 1'b0;
        if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
            m_v    = 1'b1;
            m_addr = pend[0].addr;
            m_tag  = pend[0].tag;
            void'(pend.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic [31:0] exp, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                chk(name, pc_out, exp);
                found = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: inst_valid never rose within 20 cycles, required pc %h", name, exp);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step(1);
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        bit hit;
        // Test 1: reset release, streaming at 1-cycle latency
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_first_req_valid", imem_req_valid, 1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("t1_bypass_valid", inst_valid, 1);
        chk("t1_bypass_pc", pc_out, 32'h0);
`else
        chk("t1_valid_lat1", inst_valid, 0);
        @(negedge clk);
        chk("t1_valid_lat2", inst_valid, 1);
        chk("t1_first_pc", pc_out, 32'h0);
        @(negedge clk);
        chk("t1_second_pc", pc_out, 32'h4);
`endif
        step(6);

        // Test 2: ID stall fills the queue, then drains in order
        inst_ready = 1'b0;
        do_redirect(32'h0);
        step(9);
        @(negedge clk);
        chk("t2_full_occ", occupancy, 4);
        chk("t2_full_req_valid", imem_req_valid, 0);
        chk("t2_full_head_pc", pc_out, 32'h0);
        step(1);
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_drain_valid", inst_valid, 1);
            chk("t2_drain_pc", pc_out, 32'(i * 4));
            if (i == 1) chk("t2_resume_addr", imem_req_addr, 32'h10);
        end

        // Test 3: 3-cycle memory, redirect with requests in flight
        lat = 3;
        step(8);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (last_out >= 3) hit = 1'b1;
        end
        chk("t3_outstanding_reached", hit, 1);
        step(1);
        do_redirect(32'h100);
        wait_valid(32'h100, "t3_first_pc_after_redirect");

        // Test 4: redirect coinciding with req_fire, resp and pop
        lat = 1;
        step(8);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        chk("t4_req_valid_in_redirect", imem_req_valid, 1);
        chk("t4_inst_valid_in_redirect", inst_valid, 1);
        step(1);
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_occ_after", occupancy, 0);
        chk("t4_valid_after", inst_valid, 0);
        wait_valid(32'h300, "t4_first_pc");

        // Test 5: unaligned redirect target
        step(4);
        do_redirect(32'h203);
        @(negedge clk);
        chk("t5_req_addr", imem_req_addr, 32'h200);
        wait_valid(32'h200, "t5_first_pc");

        // Test 6: asynchronous reset with entries queued and requests outstanding
        step(2);
        lat = 2;
        inst_ready = 1'b0;
        do_redirect(32'h400);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (occupancy == 3'd2 && last_out == 2) hit = 1'b1;
        end
        chk("t6_state_reached", hit, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", imem_req_valid, 0);
        chk("t6_rst_inst_valid", inst_valid, 0);
        chk("t6_rst_occ", occupancy, 0);
        chk("t6_rst_pc_out", pc_out, 0);
        chk("t6_rst_inst_out", inst_out, 0);
        lat = 1;
        inst_ready = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_restart_req_valid", imem_req_valid, 1);
        chk("t6_restart_addr", imem_req_addr, RESET_PC);
        wait_valid(RESET_PC, "t6_restart_pc");
        step(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
